// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad code checker with entry timeout, lockout,
// timed auto-relock and user password change.
module lock_sequencer #(
    parameter int unsigned         DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PWD = 16'h1234,
    parameter int unsigned         TIMEOUT_CYC = 60000000,
    parameter int unsigned         UNLOCK_CYC  = 120000000,
    parameter int unsigned         MAX_TRIES   = 3,
    parameter int unsigned         LOCKOUT_CYC = 360000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       pw_true,
    output logic       pw_false,
    output logic       timeout_flag,
    output logic       pwd_changed,
    output logic       unlocked,
    output logic       lockout,
    output logic [3:0] digit_cnt,
    output logic [2:0] fail_cnt
);
    localparam int unsigned BW = 4 * DIGITS;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTRY    = 3'd1;
    localparam logic [2:0] S_UNLOCKED = 3'd2;
    localparam logic [2:0] S_NEWPWD   = 3'd3;
    localparam logic [2:0] S_LOCKOUT  = 3'd4;

    logic [2:0]    state, state_n;
    logic [BW-1:0] buffer, buffer_n;
    logic [BW-1:0] stored, stored_n;
    logic [BW-1:0] shifted;
    logic [3:0]    cnt_n;
    logic [2:0]    fail_n;
    logic [31:0]   timer, limit;
    logic          expired, accepted, restart;
    logic          is_digit, is_star, is_hash, is_tmo;
    logic          true_n, false_n, tmo_n, chg_n;
    logic          in_entry;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == 4'hA);
    assign is_hash  = key_valid && (key_code == 4'hB);
    assign accepted = is_digit | is_star | is_hash;
    assign shifted  = (buffer << 4) | BW'(key_code);

    assign in_entry = (state == S_ENTRY) || (state == S_NEWPWD);
    assign restart  = accepted && in_entry;

    always_comb begin
        case (state)
            S_UNLOCKED: limit = 32'(UNLOCK_CYC);
            S_LOCKOUT:  limit = 32'(LOCKOUT_CYC);
            default:    limit = 32'(TIMEOUT_CYC);
        endcase
    end

    assign expired = (state != S_IDLE) && (timer == limit - 32'd1);
    // a key landing on the expiry cycle of an entry wins over the timeout
    assign is_tmo  = expired && !accepted;

    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        cnt_n    = digit_cnt;
        fail_n   = fail_cnt;
        stored_n = stored;
        true_n   = 1'b0;
        false_n  = 1'b0;
        tmo_n    = 1'b0;
        chg_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (is_digit) begin
                    state_n  = S_ENTRY;
                    buffer_n = BW'(key_code);
                    cnt_n    = 4'd1;
                end
            end
            S_ENTRY, S_NEWPWD: begin
                unique case (1'b1)
                    is_digit: begin
                        if (digit_cnt < 4'(DIGITS)) begin
                            buffer_n = shifted;
                            cnt_n    = digit_cnt + 4'd1;
                        end
                    end
                    is_star: begin
                        buffer_n = '0;
                        cnt_n    = '0;
                        if (state == S_NEWPWD)
                            state_n = S_UNLOCKED;
                    end
                    is_hash: begin
                        buffer_n = '0;
                        cnt_n    = '0;
                        if (state == S_NEWPWD) begin
                            if (digit_cnt == 4'(DIGITS)) begin
                                stored_n = buffer;
                                chg_n    = 1'b1;
                                state_n  = S_UNLOCKED;
                            end else begin
                                false_n = 1'b1;
                            end
                        end else if (digit_cnt == 4'(DIGITS)
                                     && buffer == stored) begin
                            true_n  = 1'b1;
                            fail_n  = '0;
                            state_n = S_UNLOCKED;
                        end else begin
                            false_n = 1'b1;
                            fail_n  = fail_cnt + 3'd1;
                            state_n = (fail_n == 3'(MAX_TRIES))
                                    ? S_LOCKOUT : S_IDLE;
                        end
                    end
                    is_tmo: begin
                        tmo_n    = 1'b1;
                        buffer_n = '0;
                        cnt_n    = '0;
                        state_n  = (state == S_NEWPWD)
                                 ? S_UNLOCKED : S_IDLE;
                    end
                    default: ;
                endcase
            end
            S_UNLOCKED: begin
                if (expired || is_hash) begin
                    state_n = S_IDLE;
                end else if (is_star) begin
                    state_n  = S_NEWPWD;
                    buffer_n = '0;
                    cnt_n    = '0;
                end
            end
            S_LOCKOUT: begin
                if (expired) begin
                    fail_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            buffer       <= '0;
            stored       <= DEFAULT_PWD;
            timer        <= '0;
            digit_cnt    <= '0;
            fail_cnt     <= '0;
            pw_true      <= 1'b0;
            pw_false     <= 1'b0;
            timeout_flag <= 1'b0;
            pwd_changed  <= 1'b0;
            unlocked     <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            state        <= state_n;
            buffer       <= buffer_n;
            stored       <= stored_n;
            digit_cnt    <= cnt_n;
            fail_cnt     <= fail_n;
            pw_true      <= true_n;
            pw_false     <= false_n;
            timeout_flag <= tmo_n;
            pwd_changed  <= chg_n;
            unlocked     <= (state_n == S_UNLOCKED)
                         || (state_n == S_NEWPWD);
            lockout      <= (state_n == S_LOCKOUT);
            if (state_n == S_IDLE || state_n != state || restart)
                timer <= '0;
            else
                timer <= timer + 32'd1;
        end
    end
endmodule
